pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline (F, D, E, M, W).
- Produces per-stage stall and flush strobes, including stallM/flushM for the E/M pipeline register.
- Resolves load-use hazards, multi-cycle divide occupancy, data-SRAM wait states, branch mispredicts detected in M, and exception flushes.
- Uses a small state machine plus a divide counter and an outstanding-fetch counter.

Parameters:
- DIV_CYCLES, 32: cycles the divider occupies E after div_startE is accepted (legal range 2..63).
- MAX_IFETCH, 2: maximum outstanding instruction-fetch requests tracked (saturation limit of the fetch counter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rsD, rtD  in  5 each  source registers of the instruction in D
- writeregE  in  5  destination register in E
- mem_readE, regwriteE  in  1 each  E-stage load / register-write flags
- div_startE  in  1  a valid div/divu is in E
- mem_readM, mem_writeM  in  1 each  M-stage memory access flags
- d_data_ok  in  1  data SRAM returns or acknowledges the M access
- d_req  out  1  data request enable = (mem_readM | mem_writeM) & ~exceptM & ~flushM_o
- i_req  in  1  instruction fetch issued this cycle
- i_data_ok  in  1  instruction fetch data returned
- exceptM  in  1  exception or eret committed in M
- branchM, pred_takeM, actual_takeM  in  1 each  branch resolution in M
- stallF, stallD, stallE, stallM, stallW  out  1 each
- flushF, flushD, flushE, flushM, flushW  out  1 each
- redirect_exc, redirect_br  out  1 each  PC-select strobes to fetch
- div_busy  out  1  divider occupied

Behaviour:
- Reset: all outputs 0; state=RUN; div_cnt=0; if_cnt=0.
- States: RUN, DIV, DMEM, DRAIN.
- if_cnt: +1 on i_req, -1 on i_data_ok (both in one cycle: unchanged); saturates at MAX_IFETCH and at 0.
- Event priority (highest first): exceptM > DMEM wait > mispredict > DIV > load-use.

Exception:
- In any state, exceptM forces flushD, flushE, flushM, flushW and redirect_exc for 1 cycle.
- Aborts DIV (div_cnt cleared).
- Goes to DRAIN if if_cnt!=0, else to RUN.
- d_req is suppressed the same cycle.

DRAIN:
- flushD=1 and stallF=1 until if_cnt reaches 0, then RUN.
- Returned fetches are discarded.

DMEM:
- Entered from RUN when d_req=1 and d_data_ok=0.
- Outputs: stallF, stallD, stallE, stallM=1 and flushW=1 (bubble into W).
- Leaves to RUN in the cycle d_data_ok=1; the stalls drop that same cycle.
- If d_data_ok=1 in the request cycle, no stall occurs.

Mispredict:
- Condition: branchM & (pred_takeM ^ actual_takeM), acted on only when stallM=0.
- flushF=1, flushD=1 and redirect_br=1 for 1 cycle.
- The delay slot in E is preserved.
- If stallM=1, the event is held (not lost) and acted on the first cycle M advances.

DIV:
- Entered from RUN on div_startE.
- Outputs: stallF, stallD, stallE=1, flushM=1, div_busy=1.
- div_cnt counts 0..DIV_CYCLES-1.
- On the last count: stalls drop, div_busy falls, return to RUN; E advances next edge.
- div_startE seen again in that last cycle does not re-trigger.

Load-use:
- Condition (RUN only): mem_readE & regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- Outputs: stallF, stallD=1, flushE=1 for 1 cycle.
- Combinational, no state change.

Output rules:
- All stall/flush outputs are combinational from state + inputs.
- State, div_cnt and if_cnt are registered.
- Where a flush and a stall hit the same stage, the flush wins; that stage's stall is forced 0.

Decomposition:
- Shared package: state encoding constants (RUN=0, DIV=1, DMEM=2, DRAIN=3) and the DIV_CYCLES default.
- One natural sub-module: hazard_ldu_detect (combinational load-use compare).
- The FSM and counters stay in the top module.

Test Plan:
- Load-use: lw to r5 in E, rsD=5 -> stallF=stallD=flushE=1 for exactly 1 cycle; with writeregE=0 -> no stall.
- DIV, DIV_CYCLES=32: div_startE at cycle 10 -> stallE=1 and flushM=1 for cycles 10..41, div_busy falls at 42; exceptM at cycle 20 -> flushE=1 and redirect_exc at 20, state RUN or DRAIN at 21.
- DMEM: mem_readM=1, d_data_ok low 3 cycles -> stallM=1 and flushW=1 for 3 cycles, released when d_data_ok=1; d_data_ok=1 immediately -> zero stall.
- Mispredict: pred_takeM=0, actual_takeM=1 during a DMEM stall -> no redirect until stallM drops, then flushF=flushD=redirect_br=1 for 1 cycle, flushE=0.
- Exception with if_cnt=2 -> redirect_exc 1 cycle, flushD held until 2 i_data_ok pulses, then RUN; exceptM with mem_writeM=1 -> d_req=0.
- Reset mid-DIV (rst at cnt=15) -> next cycle all outputs 0, state RUN, div_cnt=0, if_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encoding and the default parameter values.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,  // normal flow, combinational load-use / entry checks
    DIV   = 2'd1,  // divider owns E, pipeline behind it frozen
    DMEM  = 2'd2,  // waiting on data SRAM for the M access
    DRAIN = 2'd3   // after an exception, discarding in-flight fetches
  } hzState_e;

  localparam int DIV_CYCLES_DEF = 32;
  localparam int MAX_IFETCH_DEF = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_ldu_detect.sv
// hazard_ldu_detect
// Combinational load-use compare: the load in E writes a register that the
// instruction in D reads. r0 is never a real dependency.
// Ports:
//   rsD, rtD    source registers of the instruction in D
//   writeregE   destination register of the instruction in E
//   mem_readE   E instruction is a load
//   regwriteE   E instruction writes the register file
//   hit         load-use dependency present
module hazard_ldu_detect (
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] writeregE,
  input  logic       mem_readE,
  input  logic       regwriteE,
  output logic       hit
);

  assign hit = mem_readE & regwriteE & (writeregE != 5'd0) &
               ((writeregE == rsD) | (writeregE == rtD));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the F/D/E/M/W pipeline. Resolves
// exceptions, data-SRAM wait states, branch mispredicts detected in M,
// multi-cycle divides and load-use hazards. Stall/flush strobes are
// combinational from the registered state plus the current inputs.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rsD, rtD, writeregE           register ids for load-use compare
//   mem_readE, regwriteE          E-stage load / register-write flags
//   div_startE                    a valid divide sits in E
//   mem_readM, mem_writeM         M-stage memory access flags
//   d_data_ok                     data SRAM completes the M access
//   d_req                         data request enable
//   i_req, i_data_ok              fetch issued / fetch data returned
//   exceptM                       exception or eret commits in M
//   branchM, pred_takeM,
//   actual_takeM                  branch resolution in M
//   stallX / flushX               per-stage stall and flush strobes
//   redirect_exc, redirect_br     PC-select strobes to fetch
//   div_busy                      divider occupied
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int MAX_IFETCH = MAX_IFETCH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] writeregE,
  input  logic       mem_readE,
  input  logic       regwriteE,
  input  logic       div_startE,
  input  logic       mem_readM,
  input  logic       mem_writeM,
  input  logic       d_data_ok,
  output logic       d_req,
  input  logic       i_req,
  input  logic       i_data_ok,
  input  logic       exceptM,
  input  logic       branchM,
  input  logic       pred_takeM,
  input  logic       actual_takeM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushF,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       redirect_exc,
  output logic       redirect_br,
  output logic       div_busy
);

  localparam int IFW = $clog2(MAX_IFETCH + 1);
  localparam logic [IFW-1:0] IF_MAX   = IFW'(MAX_IFETCH);
  localparam logic [5:0]     DIV_LAST = 6'(DIV_CYCLES - 1);

  hzState_e       state;
  logic [5:0]     divCnt;
  logic [IFW-1:0] ifCnt, ifCntNext;
  logic           mispPend;

  logic lduHit;
  logic memAcc, dmemWait, runLike, mispNow, mispAct;
  logic divLast, divEnter, divStall, lduStall, drain;
  logic sF, sD, sE, sM, fF, fD, fE, fM, fW;

  hazard_ldu_detect uLdu (
    .rsD       (rsD),
    .rtD       (rtD),
    .writeregE (writeregE),
    .mem_readE (mem_readE),
    .regwriteE (regwriteE),
    .hit       (lduHit)
  );

  // Outstanding-fetch counter, saturating at both ends; simultaneous
  // issue and return cancel out.
  always_comb begin
    ifCntNext = ifCnt;
    if (i_req && !i_data_ok && ifCnt != IF_MAX)
      ifCntNext = ifCnt + IFW'(1);
    else if (!i_req && i_data_ok && ifCnt != '0)
      ifCntNext = ifCnt - IFW'(1);
  end

  always_comb begin
    memAcc   = mem_readM | mem_writeM;
    // M waits on the SRAM: new request missing its ack in RUN, or still
    // unacknowledged in DMEM. An exception pre-empts the wait.
    dmemWait = ~exceptM & ~d_data_ok &
               ((state == RUN & memAcc) | (state == DMEM));
    // The DMEM release cycle lets E/D advance exactly like RUN, so a divide
    // or load-use parked behind the wait is picked up there rather than
    // slipping through unstalled.
    runLike  = ~exceptM & ((state == RUN) | (state == DMEM & d_data_ok));
    mispNow  = branchM & (pred_takeM ^ actual_takeM);
    // A mispredict only redirects once M is moving; until then it is held.
    mispAct  = ~exceptM & ~dmemWait & (mispNow | mispPend);
    divLast  = (state == DIV) & (divCnt == DIV_LAST);
    divEnter = runLike & ~dmemWait & div_startE;
    divStall = ~exceptM & (divEnter | (state == DIV & ~divLast));
    lduStall = runLike & ~dmemWait & ~divEnter & ~mispAct & lduHit;
    drain    = ~exceptM & (state == DRAIN);

    fF = mispAct;
    fD = exceptM | mispAct | drain;
    fE = exceptM | lduStall;
    fM = exceptM | divStall;
    fW = exceptM | dmemWait;

    sF = dmemWait | divStall | lduStall | drain;
    sD = dmemWait | divStall | lduStall;
    sE = dmemWait | divStall;
    sM = dmemWait;
  end

  // A flush overrides a stall on the same stage.
  assign stallF       = ~rst & sF & ~fF;
  assign stallD       = ~rst & sD & ~fD;
  assign stallE       = ~rst & sE & ~fE;
  assign stallM       = ~rst & sM & ~fM;
  assign stallW       = 1'b0;
  assign flushF       = ~rst & fF;
  assign flushD       = ~rst & fD;
  assign flushE       = ~rst & fE;
  assign flushM       = ~rst & fM;
  assign flushW       = ~rst & fW;
  assign redirect_exc = ~rst & exceptM;
  assign redirect_br  = ~rst & mispAct;
  assign div_busy     = ~rst & divStall;
  assign d_req        = ~rst & memAcc & ~exceptM & ~fM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      divCnt   <= '0;
      ifCnt    <= '0;
      mispPend <= 1'b0;
    end else begin
      ifCnt    <= ifCntNext;
      mispPend <= ~exceptM & dmemWait & (mispNow | mispPend);
      if (exceptM) begin
        divCnt <= '0;
        state  <= (ifCntNext != '0) ? DRAIN : RUN;
      end else begin
        unique case (state)
          RUN, DMEM: begin
            if (dmemWait) begin
              state <= DMEM;
            end else if (divEnter) begin
              state  <= DIV;
              divCnt <= '0;
            end else begin
              state <= RUN;
            end
          end
          DIV: begin
            if (divLast) begin
              state  <= RUN;
              divCnt <= '0;
            end else begin
              divCnt <= divCnt + 6'd1;
            end
          end
          DRAIN: begin
            if (ifCntNext == '0) state <= RUN;
          end
        endcase
      end
    end
  end

endmodule
